// File: rtl/hazard_control_unit_if.sv
// Purpose: bundles the ID/EX hazard inputs and the stall/flush/status outputs
//          of hazard_control_unit.
// Ports (signals):
//   ID_rs, ID_rt, ID_uses_rt, ID_halt         fields of the instruction in ID
//   EX_mem_read, EX_rt, EX_branch_taken       fields of the instruction in EX
//   o_pc_write, o_if_id_write                 load enables (combinational)
//   o_if_id_flush, o_id_ex_flush              squash controls (combinational)
//   o_halted, o_stall_count, o_flush_count    registered status/counters
// Modports: master drives the hazard inputs, slave is the control unit.
interface hazard_control_unit_if #(
    parameter int unsigned NB_REG = 5,
    parameter int unsigned NB_CNT = 16
);
    logic [NB_REG-1:0] ID_rs;
    logic [NB_REG-1:0] ID_rt;
    logic              ID_uses_rt;
    logic              ID_halt;
    logic              EX_mem_read;
    logic [NB_REG-1:0] EX_rt;
    logic              EX_branch_taken;
    logic              o_pc_write;
    logic              o_if_id_write;
    logic              o_if_id_flush;
    logic              o_id_ex_flush;
    logic              o_halted;
    logic [NB_CNT-1:0] o_stall_count;
    logic [NB_CNT-1:0] o_flush_count;

    modport master (
        output ID_rs, ID_rt, ID_uses_rt, ID_halt, EX_mem_read, EX_rt, EX_branch_taken,
        input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
        input  o_halted, o_stall_count, o_flush_count
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, ID_halt, EX_mem_read, EX_rt, EX_branch_taken,
        output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
        output o_halted, o_stall_count, o_flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Purpose: pipeline hazard control. Detects load-use hazards and taken
//          branches resolved in EX, sequences HALT (freeze fetch, drain
//          EX/MEM/WB, report halted) and keeps saturating stall/flush counters.
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   synchronous, active-high reset
//   bus       hazard_control_unit_if.slave; stall/flush outputs are Mealy
//             (same-cycle), o_halted and the counters are registered.
module hazard_control_unit #(
    parameter int unsigned NB_REG       = 5,
    parameter int unsigned NB_CNT       = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    hazard_control_unit_if.slave  bus
);
    localparam int unsigned NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t            state, state_next;
    logic [NB_DRN-1:0] drain_q, drain_next;
    logic [NB_CNT-1:0] stall_q, flush_q;
    logic              halted_q;
    logic              inc_stall, inc_flush;
    logic [NB_REG-1:0] ex_rt;
    logic              load_use;

    assign ex_rt    = bus.EX_rt;
    assign load_use = bus.EX_mem_read && (ex_rt != '0) &&
                      ((ex_rt == bus.ID_rs) || (bus.ID_uses_rt && (ex_rt == bus.ID_rt)));

    // Next state, drain count, counter strobes and Mealy stall/flush controls
    always_comb begin
        state_next        = state;
        drain_next        = drain_q;
        inc_stall         = 1'b0;
        inc_flush         = 1'b0;
        bus.o_pc_write    = 1'b1;
        bus.o_if_id_write = 1'b1;
        bus.o_if_id_flush = 1'b0;
        bus.o_id_ex_flush = 1'b0;

        unique case (state)
            RUN: begin
                if (bus.EX_branch_taken) begin
                    // load_use and halt belong to instructions being squashed
                    bus.o_if_id_flush = 1'b1;
                    bus.o_id_ex_flush = 1'b1;
                    inc_flush         = 1'b1;
                end else if (load_use) begin
                    bus.o_pc_write    = 1'b0;
                    bus.o_if_id_write = 1'b0;
                    bus.o_id_ex_flush = 1'b1;
                    inc_stall         = 1'b1;
                end else if (bus.ID_halt) begin
                    bus.o_pc_write    = 1'b0;
                    bus.o_if_id_write = 1'b0;
                    bus.o_id_ex_flush = 1'b1;
                    drain_next        = NB_DRN'(DRAIN_CYCLES - 1);
                    state_next        = DRAIN;
                end
            end
            DRAIN, HALTED: begin
                bus.o_pc_write    = 1'b0;
                bus.o_if_id_write = 1'b0;
                bus.o_id_ex_flush = 1'b1;
                if (state == DRAIN) begin
                    if (drain_q == '0) begin
                        state_next = HALTED;
                    end else begin
                        drain_next = drain_q - NB_DRN'(1);
                    end
                end
            end
            default: state_next = RUN;
        endcase

        if (i_reset) begin
            state_next        = RUN;
            drain_next        = '0;
            inc_stall         = 1'b0;
            inc_flush         = 1'b0;
            bus.o_pc_write    = 1'b0;
            bus.o_if_id_write = 1'b0;
            bus.o_if_id_flush = 1'b1;
            bus.o_id_ex_flush = 1'b1;
        end
    end

    // State, drain counter, halted flag and saturating performance counters
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state    <= state_next;
            drain_q  <= drain_next;
            halted_q <= (state_next == HALTED);
            if (inc_stall && (stall_q != '1)) stall_q <= stall_q + NB_CNT'(1);
            if (inc_flush && (flush_q != '1)) flush_q <= flush_q + NB_CNT'(1);
        end
    end

    assign bus.o_halted      = halted_q;
    assign bus.o_stall_count = stall_q;
    assign bus.o_flush_count = flush_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose: self-checking bench for hazard_control_unit (NB_CNT=2 so that
//          counter saturation is reachable) using directed steps followed by
//          random stimulus against an abstract reference model.
module tb_hazard_control_unit;
    localparam int unsigned NB_REG = 5;
    localparam int unsigned NB_CNT = 2;
    localparam int unsigned DRAIN  = 3;
    localparam int          CMAX   = (1 << NB_CNT) - 1;

    logic i_clock = 1'b0;
    logic i_reset;
    always #5 i_clock = ~i_clock;

    hazard_control_unit_if #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) bus ();

    hazard_control_unit #(
        .NB_REG(NB_REG), .NB_CNT(NB_CNT), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: running unless draining/halted; drain_left counts remaining drain cycles
    bit m_halted     = 1'b0;
    int m_drain_left = 0;
    int m_stall      = 0;
    int m_flush      = 0;
    int halt_edges   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check Mealy outputs, clock, check registered outputs
    task automatic step(input int rst, input int rs, input int rt, input int uses,
                        input int halt, input int mr, input int ert, input int br);
        logic [3:0] exp_ctl;
        bit lu;
        @(negedge i_clock);
        i_reset             = rst[0];
        bus.ID_rs           = NB_REG'(rs);
        bus.ID_rt           = NB_REG'(rt);
        bus.ID_uses_rt      = uses[0];
        bus.ID_halt         = halt[0];
        bus.EX_mem_read     = mr[0];
        bus.EX_rt           = NB_REG'(ert);
        bus.EX_branch_taken = br[0];
        lu = (mr != 0) && (ert != 0) && ((ert == rs) || ((uses != 0) && (ert == rt)));
        // {pc_write, if_id_write, if_id_flush, id_ex_flush}
        if (rst != 0)                          exp_ctl = 4'b0011;
        else if (m_halted || m_drain_left > 0) exp_ctl = 4'b0001;
        else if (br != 0)                      exp_ctl = 4'b1111;
        else if (lu)                           exp_ctl = 4'b0001;
        else if (halt != 0)                    exp_ctl = 4'b0001;
        else                                   exp_ctl = 4'b1100;
        #1;
        chk("ctl", 32'({bus.o_pc_write, bus.o_if_id_write, bus.o_if_id_flush, bus.o_id_ex_flush}),
            32'(exp_ctl));
        @(posedge i_clock);
        if (rst != 0) begin
            m_halted = 1'b0; m_drain_left = 0; m_stall = 0; m_flush = 0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
        end else if (br != 0) begin
            m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end else if (lu) begin
            m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end else if (halt != 0) begin
            m_drain_left = DRAIN;
        end
        #1;
        chk("halted", 32'(bus.o_halted), 32'(m_halted));
        chk("stall_count", 32'(bus.o_stall_count), 32'(m_stall));
        chk("flush_count", 32'(bus.o_flush_count), 32'(m_flush));
    endtask

    task automatic idle();
        step(0, 1, 2, 1, 0, 0, 3, 0);
    endtask

    initial begin
        i_reset = 1'b1;
        bus.ID_rs = '0; bus.ID_rt = '0; bus.ID_uses_rt = 1'b0; bus.ID_halt = 1'b0;
        bus.EX_mem_read = 1'b0; bus.EX_rt = '0; bus.EX_branch_taken = 1'b0;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // load-use on rs
        step(0, 5, 0, 0, 0, 1, 5, 0);
        // suppression: r0 destination, rt match without rt use
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 3, 7, 0, 0, 1, 7, 0);
        // rt match with rt use
        step(0, 3, 7, 1, 0, 1, 7, 0);
        // branch over load-use
        step(0, 5, 0, 0, 0, 1, 5, 1);
        // saturation
        repeat (5) step(0, 9, 0, 0, 0, 1, 9, 0);
        chk("stall_sat", 32'(bus.o_stall_count), 32'(3));

        // halt pulse: o_halted on the 4th edge, then stays high with junk inputs
        step(0, 1, 2, 0, 1, 0, 3, 0);
        halt_edges = 1;
        while (!bus.o_halted && halt_edges < 10) begin
            step(0, 4, 4, 1, 1, 1, 4, 1);
            halt_edges++;
        end
        chk("halt_latency", 32'(halt_edges), 32'(DRAIN + 1));
        repeat (4) step(0, 4, 4, 1, 1, 1, 4, 1);

        // reset in HALTED
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // branch vs halt in the same cycle: stays running
        step(0, 1, 2, 0, 1, 0, 3, 1);
        repeat (6) idle();

        // reset mid-drain
        step(0, 1, 2, 0, 1, 0, 3, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1 : 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 14) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
